// File: rtl/frame_sync_pkg.sv
// Shared state encoding and reset values for the game-to-pixel frame sync.
// Reset constants are sized for the default obstacle/player widths.
package frame_sync_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_WAIT_VB,
      ST_COPY,
      ST_COMMIT
   } state_e;

   localparam logic [19:0] OBS_X_RST    = {10'd700, 10'd700};
   localparam logic [17:0] OBS_Y_RST    = {9'd500, 9'd500};
   localparam logic [8:0]  PLAYER_Y_RST = 9'd240;
   localparam logic [1:0]  GAMEMODE_RST = 2'd0;

endpackage

// File: rtl/frame_sync_ctrl_tick_sync.sv
// Two-flop synchronizer for the asynchronous game tick plus a rising-edge
// detector producing a single-cycle pulse in the pixel clock domain.
module tick_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/frame_sync_ctrl.sv
// Captures game-domain display state once per tick and commits it to the
// pixel-domain display registers only during vertical blanking.
module frame_sync_ctrl
   import frame_sync_pkg::*;
#(
   parameter int N_OBS  = 10,
   parameter int OBS_XW = 20,
   parameter int OBS_YW = 18,
   parameter int PY_W   = 9,
   parameter int SETTLE = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    game_tick,
   input  logic                    vblank,
   input  logic [N_OBS*OBS_XW-1:0] obstacle_x_in,
   input  logic [N_OBS*OBS_YW-1:0] obstacle_y_in,
   input  logic [PY_W-1:0]         player_y_in,
   input  logic [1:0]              gamemode_in,
   output logic [N_OBS*OBS_XW-1:0] obstacle_x_out,
   output logic [N_OBS*OBS_YW-1:0] obstacle_y_out,
   output logic [PY_W-1:0]         player_y_out,
   output logic [1:0]              gamemode_out,
   output logic                    swap_pulse,
   output logic                    busy,
   output logic [7:0]              drop_cnt
);

   localparam int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1;
   localparam logic [OBS_XW-1:0] X_RST = OBS_XW'(OBS_X_RST);
   localparam logic [OBS_YW-1:0] Y_RST = OBS_YW'(OBS_Y_RST);
   localparam logic [PY_W-1:0]   P_RST = PY_W'(PLAYER_Y_RST);

   logic tick_rise;

   tick_sync u_tick_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (game_tick),
      .rise     (tick_rise)
   );

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               pend_q, pend_d;
   logic [7:0]         drop_q, drop_d;
   logic               busy_q;

   logic [N_OBS-1:0][OBS_XW-1:0] stg_x_q, out_x_q;
   logic [N_OBS-1:0][OBS_YW-1:0] stg_y_q, out_y_q;
   logic [PY_W-1:0]              stg_py_q, out_py_q;
   logic [1:0]                   stg_gm_q, out_gm_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      drop_d  = drop_q;
      if (tick_rise && state_q != ST_IDLE) begin
         pend_d = 1'b1;
         if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      unique case (state_q)
         ST_IDLE: begin
            if (tick_rise) begin
               state_d = ST_SETTLE;
               cnt_d   = 4'(SETTLE);
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd1) state_d = ST_CAPTURE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         ST_CAPTURE: state_d = ST_WAIT_VB;
         ST_WAIT_VB: begin
            if (vblank) begin
               state_d = ST_COPY;
               idx_d   = '0;
            end
         end
         ST_COPY: begin
            if (idx_q == IDX_W'(N_OBS - 1)) state_d = ST_COMMIT;
            else                            idx_d   = idx_q + IDX_W'(1);
         end
         ST_COMMIT: begin
            // ticks seen during this frame coalesce into one follow-up frame
            pend_d = 1'b0;
            if (pend_q || tick_rise) begin
               state_d = ST_SETTLE;
               cnt_d   = 4'(SETTLE);
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         drop_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg_x_q  <= {N_OBS{X_RST}};
         stg_y_q  <= {N_OBS{Y_RST}};
         stg_py_q <= P_RST;
         stg_gm_q <= GAMEMODE_RST;
         out_x_q  <= {N_OBS{X_RST}};
         out_y_q  <= {N_OBS{Y_RST}};
         out_py_q <= P_RST;
         out_gm_q <= GAMEMODE_RST;
      end else begin
         if (state_q == ST_CAPTURE) begin
            stg_x_q  <= obstacle_x_in;
            stg_y_q  <= obstacle_y_in;
            stg_py_q <= player_y_in;
            stg_gm_q <= gamemode_in;
         end
         if (state_q == ST_COPY) begin
            out_x_q[idx_q] <= stg_x_q[idx_q];
            out_y_q[idx_q] <= stg_y_q[idx_q];
         end
         if (state_q == ST_COMMIT) begin
            out_py_q <= stg_py_q;
            out_gm_q <= stg_gm_q;
         end
      end
   end

   assign obstacle_x_out = out_x_q;
   assign obstacle_y_out = out_y_q;
   assign player_y_out   = out_py_q;
   assign gamemode_out   = out_gm_q;
   assign swap_pulse     = (state_q == ST_COMMIT);
   assign busy           = busy_q;
   assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed self-checking bench for frame_sync_ctrl.
// Each scenario task drives stimulus and checks expected frames inline.
module tb_frame_sync_ctrl;

   localparam int N  = 10;
   localparam int XW = 20;
   localparam int YW = 18;
   localparam int PW = 9;
   localparam int FW = N*XW + N*YW + PW + 2;
   localparam int RS = 9;

   typedef logic [N*XW-1:0] vx_t;
   typedef logic [N*YW-1:0] vy_t;
   typedef logic [FW-1:0]   fr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          game_tick = 1'b0;
   logic          vblank = 1'b0;
   vx_t           ox_i, ox_o;
   vy_t           oy_i, oy_o;
   logic [PW-1:0] py_i, py_o;
   logic [1:0]    gm_i, gm_o;
   logic          swap, busy;
   logic [7:0]    drop;

   int errors = 0;
   int checks = 0;

   frame_sync_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .game_tick      (game_tick),
      .vblank         (vblank),
      .obstacle_x_in  (ox_i),
      .obstacle_y_in  (oy_i),
      .player_y_in    (py_i),
      .gamemode_in    (gm_i),
      .obstacle_x_out (ox_o),
      .obstacle_y_out (oy_o),
      .player_y_out   (py_o),
      .gamemode_out   (gm_o),
      .swap_pulse     (swap),
      .busy           (busy),
      .drop_cnt       (drop)
   );

   always #5 clk = ~clk;

   function automatic vx_t fx(int s);
      vx_t v;
      for (int i = 0; i < N; i++)
         case (s)
            0:       v[i*XW +: XW] = XW'(i*3);
            1:       v[i*XW +: XW] = XW'(i*7 + 100);
            2:       v[i*XW +: XW] = XW'(1000 + i);
            3:       v[i*XW +: XW] = XW'(20'hABCDE ^ i);
            default: v[i*XW +: XW] = {10'd700, 10'd700};
         endcase
      return v;
   endfunction

   function automatic vy_t fy(int s);
      vy_t v;
      for (int i = 0; i < N; i++)
         case (s)
            0:       v[i*YW +: YW] = YW'(i*5 + 1);
            1:       v[i*YW +: YW] = YW'(i + 200);
            2:       v[i*YW +: YW] = YW'(300 + i);
            3:       v[i*YW +: YW] = YW'(18'h1234 + i);
            default: v[i*YW +: YW] = {9'd500, 9'd500};
         endcase
      return v;
   endfunction

   function automatic logic [PW-1:0] fpy(int s);
      case (s)
         0:       return 9'd100;
         1:       return 9'd50;
         2:       return 9'd77;
         3:       return 9'd200;
         default: return 9'd240;
      endcase
   endfunction

   function automatic logic [1:0] fgm(int s);
      case (s)
         0:       return 2'd1;
         1:       return 2'd2;
         2:       return 2'd3;
         3:       return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   function automatic fr_t fr(int s);
      return {fx(s), fy(s), fpy(s), fgm(s)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int s);
      ox_i = fx(s);
      oy_i = fy(s);
      py_i = fpy(s);
      gm_i = fgm(s);
   endtask

   task automatic test_reset();
      drive(0);
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(RS)) begin
         errors++;
         $display("FAIL reset_frame got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(RS));
      end
      checks++;
      if ({busy, swap, drop} !== 10'd0) begin
         errors++;
         $display("FAIL reset_ctl got busy=%b swap=%b drop=%0d exp 0", busy, swap, drop);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int n;
      drive(0);
      vblank = 1'b0;
      game_tick = 1'b1;
      step();
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_early got %b exp 0", busy);
      end
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_set got %b exp 1", busy);
      end
      game_tick = 1'b0;
      repeat (9) step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o, swap} !== {fr(RS), 1'b0}) begin
         errors++;
         $display("FAIL basic_hold got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(RS));
      end
      vblank = 1'b1;
      n = 0;
      while (swap !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (n !== 11) begin
         errors++;
         $display("FAIL basic_swap_latency got %0d exp 11", n);
      end
      step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(0)) begin
         errors++;
         $display("FAIL basic_frame got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(0));
      end
      checks++;
      if ({busy, swap} !== 2'b00) begin
         errors++;
         $display("FAIL basic_idle got busy=%b swap=%b exp 0 0", busy, swap);
      end
      vblank = 1'b0;
      step();
   endtask

   task automatic test_capture_hold();
      int n;
      drive(1);
      game_tick = 1'b1;
      repeat (3) step();
      game_tick = 1'b0;
      repeat (9) step();
      drive(2);
      repeat (2) step();
      vblank = 1'b1;
      n = 0;
      while (swap !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(1)) begin
         errors++;
         $display("FAIL hold_frame got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(1));
      end
      vblank = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      drive(2);
      game_tick = 1'b1;
      repeat (3) step();
      game_tick = 1'b0;
      repeat (9) step();
      drive(3);
      game_tick = 1'b1;
      repeat (3) step();
      game_tick = 1'b0;
      checks++;
      if (drop !== 8'd1) begin
         errors++;
         $display("FAIL b2b_drop got %0d exp 1", drop);
      end
      vblank = 1'b1;
      n = 0;
      while (swap !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(2)) begin
         errors++;
         $display("FAIL b2b_first got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(2));
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_resettle got busy=%b exp 1", busy);
      end
      n = 0;
      while (swap !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o, busy} !== {fr(3), 1'b0}) begin
         errors++;
         $display("FAIL b2b_second got %h busy=%b exp %h", {ox_o, oy_o, py_o, gm_o}, busy, fr(3));
      end
      vblank = 1'b0;
      step();
   endtask

   task automatic test_saturate();
      int swaps;
      swaps = 0;
      drive(2);
      vblank = 1'b0;
      for (int t = 0; t < 300; t++) begin
         game_tick = 1'b1;
         step();
         swaps += int'(swap);
         step();
         swaps += int'(swap);
         game_tick = 1'b0;
         step();
         swaps += int'(swap);
         step();
         swaps += int'(swap);
         if (t == 9) begin
            checks++;
            if (drop !== 8'd10) begin
               errors++;
               $display("FAIL sat_partial got %0d exp 10", drop);
            end
         end
      end
      checks++;
      if (drop !== 8'd255) begin
         errors++;
         $display("FAIL sat_drop got %0d exp 255", drop);
      end
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(3) || swaps !== 0) begin
         errors++;
         $display("FAIL sat_hold got %h swaps=%0d exp %h 0", {ox_o, oy_o, py_o, gm_o}, swaps, fr(3));
      end
   endtask

   task automatic test_reset_mid_copy();
      vx_t tmp;
      tmp = fx(2);
      vblank = 1'b1;
      repeat (6) step();
      checks++;
      if (ox_o[XW-1:0] !== tmp[XW-1:0]) begin
         errors++;
         $display("FAIL midcopy_entry0 got %h exp %h", ox_o[XW-1:0], tmp[XW-1:0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(RS)) begin
         errors++;
         $display("FAIL midcopy_reset got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(RS));
      end
      checks++;
      if ({busy, swap, drop} !== 10'd0) begin
         errors++;
         $display("FAIL midcopy_ctl got busy=%b swap=%b drop=%0d exp 0", busy, swap, drop);
      end
      vblank = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_vblank_early();
      int n;
      int swaps;
      drive(0);
      vblank = 1'b1;
      game_tick = 1'b1;
      n = 0;
      while (swap !== 1'b1 && n < 50) begin
         step();
         n++;
         if (n == 3) game_tick = 1'b0;
         if (n == 12) vblank = 1'b0;
      end
      checks++;
      if (n !== 19) begin
         errors++;
         $display("FAIL early_swap_latency got %0d exp 19", n);
      end
      step();
      checks++;
      if ({ox_o, oy_o, py_o, gm_o} !== fr(0)) begin
         errors++;
         $display("FAIL early_frame got %h exp %h", {ox_o, oy_o, py_o, gm_o}, fr(0));
      end
      swaps = 0;
      repeat (10) begin
         swaps += int'(swap);
         step();
      end
      checks++;
      if (swaps !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL early_single got swaps=%0d busy=%b exp 0 0", swaps, busy);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_capture_hold();
      test_back_to_back();
      test_saturate();
      test_reset_mid_copy();
      test_vblank_early();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
